// File: rtl/arith_pkg.sv
// Shared types and default sizing for the digit-serial arithmetic blocks.
package arith_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultDigit = 4;

    typedef enum logic {IDLE, RUN} serial_state_t;

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit.
module digit_adder
    import arith_pkg::*;
#(
    parameter int unsigned DIGIT = DefaultDigit
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_in_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             c_out_o,
    output logic             c_msb_o
);

    logic [DIGIT:0] carry;

    assign carry[0] = c_in_i;

    for (genvar i = 0; i < DIGIT; i++) begin : gen_fa
        full_adder_1_bit u_fa (
            .a_i    (a_i[i]),
            .b_i    (b_i[i]),
            .c_in_i (carry[i]),
            .sum_o  (sum_o[i]),
            .c_out_o(carry[i+1])
        );
    end

    assign c_out_o = carry[DIGIT];
    assign c_msb_o = carry[DIGIT-1];

endmodule

// File: rtl/full_adder_1_bit.sv
// Single-bit full adder cell used to build the digit ripple chain.
module full_adder_1_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_in_i,
    output logic sum_o,
    output logic c_out_o
);

    logic p;

    assign p       = a_i ^ b_i;
    assign sum_o   = p ^ c_in_i;
    assign c_out_o = (a_i & b_i) | (c_in_i & p);

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSD first, carry held between cycles.
module digit_serial_adder
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DIGIT = DefaultDigit
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out_o,
    output logic             overflow_o
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NDIG - 1);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : gen_param_check
        $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    serial_state_t   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d, ovf_q, ovf_d, done_q, done_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout, dig_cmsb;
    logic [WIDTH-1:0] res_next;

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit_adder (
        .a_i    (a_q[DIGIT-1:0]),
        .b_i    (b_q[DIGIT-1:0]),
        .c_in_i (carry_q),
        .sum_o  (dig_sum),
        .c_out_o(dig_cout),
        .c_msb_o(dig_cmsb)
    );

    // New digit enters at the top; after NDIG shifts the word is aligned.
    assign res_next = WIDTH'({dig_sum, res_q} >> DIGIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    a_d     = a_i;
                    b_d     = sub_i ? ~b_i : b_i;
                    carry_d = sub_i ? 1'b1 : c_in_i;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_next;
                carry_d = dig_cout;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = IDLE;
                    sum_d   = res_next;
                    c_out_d = dig_cout;
                    ovf_d   = dig_cmsb ^ dig_cout;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy_o     = (state_q == RUN);
    assign done_o     = done_q;
    assign sum_o      = sum_q;
    assign c_out_o    = c_out_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: four DIGIT sizes share stimulus, checked against a word-level model.
module tb_digit_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;

    logic        d_busy [4];
    logic        d_done [4];
    logic [15:0] d_sum  [4];
    logic        d_cout [4];
    logic        d_ovf  [4];

    int checks   = 0;
    int failures = 0;

    // Instance latencies: DIGIT = 4, 1, 8, 16 on a 16-bit word.
    int lat [4] = '{4, 16, 2, 1};

    logic        m_busy [4];
    logic        m_done [4];
    logic [17:0] m_res  [4];
    logic [17:0] p_res  [4];
    int          rem    [4];

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .sub_i(sub), .a_i(a), .b_i(b),
        .c_in_i(c_in), .busy_o(d_busy[0]), .done_o(d_done[0]), .sum_o(d_sum[0]),
        .c_out_o(d_cout[0]), .overflow_o(d_ovf[0])
    );
    digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_dut_d1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .sub_i(sub), .a_i(a), .b_i(b),
        .c_in_i(c_in), .busy_o(d_busy[1]), .done_o(d_done[1]), .sum_o(d_sum[1]),
        .c_out_o(d_cout[1]), .overflow_o(d_ovf[1])
    );
    digit_serial_adder #(.WIDTH(16), .DIGIT(8)) u_dut_d8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .sub_i(sub), .a_i(a), .b_i(b),
        .c_in_i(c_in), .busy_o(d_busy[2]), .done_o(d_done[2]), .sum_o(d_sum[2]),
        .c_out_o(d_cout[2]), .overflow_o(d_ovf[2])
    );
    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut_d16 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .sub_i(sub), .a_i(a), .b_i(b),
        .c_in_i(c_in), .busy_o(d_busy[3]), .done_o(d_done[3]), .sum_o(d_sum[3]),
        .c_out_o(d_cout[3]), .overflow_o(d_ovf[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {overflow, c_out, sum} from plain word arithmetic.
    function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                           input logic ci, input logic s);
        logic [16:0] t;
        logic [15:0] r;
        logic        co;
        logic        v;
        if (s) begin
            r  = x - y;
            co = (x >= y);
            v  = (x[15] != y[15]) && (r[15] != x[15]);
        end else begin
            t  = {1'b0, x} + {1'b0, y} + {16'd0, ci};
            r  = t[15:0];
            co = t[16];
            v  = (x[15] == y[15]) && (r[15] != x[15]);
        end
        return {v, co, r};
    endfunction

    task automatic check(input string nm, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s inst=%0d got=%h want=%h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_res[i]  <= '0;
                p_res[i]  <= '0;
                rem[i]    <= 0;
            end else begin
                m_done[i] <= 1'b0;
                if (!m_busy[i]) begin
                    if (start) begin
                        m_busy[i] <= 1'b1;
                        rem[i]    <= lat[i] - 1;
                        p_res[i]  <= ref_op(a, b, c_in, sub);
                    end
                end else if (rem[i] == 0) begin
                    m_busy[i] <= 1'b0;
                    m_res[i]  <= p_res[i];
                    m_done[i] <= 1'b1;
                end else begin
                    rem[i] <= rem[i] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            check("busy", i, 32'(d_busy[i]), 32'(m_busy[i]));
            check("done", i, 32'(d_done[i]), 32'(m_done[i]));
            check("sum", i, 32'(d_sum[i]), 32'(m_res[i][15:0]));
            check("c_out", i, 32'(d_cout[i]), 32'(m_res[i][16]));
            check("overflow", i, 32'(d_ovf[i]), 32'(m_res[i][17]));
        end
    end

    task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic ci,
                         input logic s, input logic hold);
        @(posedge clk);
        #2;
        a     = x;
        b     = y;
        c_in  = ci;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #2;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (d_busy[0]) nb++;
        end while (!d_done[0] && n < 40);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((d_busy[0] || d_busy[1] || d_busy[2] || d_busy[3]) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", 0, (n >= 40) ? 32'd1 : 32'd0, 32'd0);
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        s;
        logic [15:0] sum;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [5] = '{
        '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1}
    };

    initial begin
        int n;
        int nb;
        int nd;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 0, 32'(d_busy[0]), 32'd0);
        check("rst_done", 0, 32'(d_done[0]), 32'd0);
        check("rst_sum", 0, 32'(d_sum[0]), 32'd0);
        check("rst_cout_ovf", 0, {30'd0, d_cout[0], d_ovf[0]}, 32'd0);
        #1;
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            wait_idle();
            issue(vecs[k].a, vecs[k].b, vecs[k].ci, vecs[k].s, 1'b0);
            check("busy_after_start", k, 32'(d_busy[0]), 32'd1);
            wait_done(n, nb);
            check("latency", k, 32'(n), 32'd4);
            check("busy_cycles", k, 32'(nb + 1), 32'd4);
            check("vec_sum", k, 32'(d_sum[0]), 32'(vecs[k].sum));
            check("vec_cout", k, 32'(d_cout[0]), 32'(vecs[k].co));
            check("vec_ovf", k, 32'(d_ovf[0]), 32'(vecs[k].ov));
        end

        // Second start mid-run must be ignored.
        wait_idle();
        issue(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        a     = 16'h1111;
        b     = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(n, nb);
        check("midrun_latency", 0, 32'(n), 32'd2);
        check("midrun_sum", 0, 32'(d_sum[0]), 32'h0007);

        // Start held through the done cycle is taken at the edge that ends it.
        wait_idle();
        issue(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b1);
        a = 16'h1234;
        b = 16'h1111;
        wait_done(n, nb);
        check("b2b_first_latency", 0, 32'(n), 32'd4);
        check("b2b_first_sum", 0, 32'(d_sum[0]), 32'h0030);
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(n, nb);
        check("b2b_second_latency", 0, 32'(n), 32'd4);
        check("b2b_second_sum", 0, 32'(d_sum[0]), 32'h2345);

        // Reset in RUN cycle 2 clears outputs at once and suppresses done.
        wait_idle();
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 0, 32'(d_busy[0]), 32'd0);
        check("abort_done", 0, 32'(d_done[0]), 32'd0);
        check("abort_sum", 0, 32'(d_sum[0]), 32'd0);
        check("abort_cout_ovf", 0, {30'd0, d_cout[0], d_ovf[0]}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        nd = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (d_done[0]) nd++;
        end
        check("abort_no_done", 0, 32'(nd), 32'd0);

        // First edge after reset release honours start.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        a     = 16'h0001;
        b     = 16'h0002;
        sub   = 1'b0;
        c_in  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(n, nb);
        check("post_reset_latency", 0, 32'(n), 32'd4);
        check("post_reset_sum", 0, 32'(d_sum[0]), 32'h0003);

        // Random operands across all DIGIT sizes, checked by the model every cycle.
        for (int k = 0; k < 10; k++) begin
            wait_idle();
            issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        wait_idle();
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
